// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Shares one single-port video RAM between the CPU data port and
//            the scan-out fetcher; video has priority, bounded by a burst limit.
// Revision : 1.0  initial release
// ============================================================================
module vram_arbiter #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 16,
    parameter int VID_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [3:0] c_BURST_MAX = 4'(VID_BURST);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_owner_cpu;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic [DATA_W-1:0]   r_vid_rdata;
    logic [3:0]          r_burst;

    logic                w_any_req;
    logic                w_grant_vid;
    logic                w_cpu_rd_now;
    logic                w_vid_rd_now;

    assign w_any_req   = cpu_req | vid_req;
    // Video wins unless its burst allowance is used up; with no CPU request
    // pending the owner defaults to video.
    assign w_grant_vid = (vid_req & (r_burst < c_BURST_MAX)) | ~cpu_req;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_next = S_ACCESS;
            S_ACCESS: w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_owner_cpu <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_vid_rdata <= '0;
            r_burst     <= 4'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE) begin
                if (w_any_req) begin
                    r_owner_cpu <= ~w_grant_vid;
                    r_we        <= ~w_grant_vid & cpu_we;
                    r_addr      <= w_grant_vid ? vid_addr : cpu_addr;
                    r_wdata     <= cpu_wdata;
                end
                if (!cpu_req || !w_grant_vid) begin
                    r_burst <= 4'd0;
                end else if (w_any_req) begin
                    r_burst <= (r_burst < c_BURST_MAX) ? r_burst + 4'd1 : c_BURST_MAX;
                end
            end
            if (w_cpu_rd_now) r_cpu_rdata <= mem_rdata;
            if (w_vid_rd_now) r_vid_rdata <= mem_rdata;
        end
    end

    // Read data is presented straight from the RAM during the ack cycle and
    // held in a register afterwards.
    assign w_cpu_rd_now = (r_state == S_RESP) &  r_owner_cpu & ~r_we;
    assign w_vid_rd_now = (r_state == S_RESP) & ~r_owner_cpu;

    assign cpu_ack   = (r_state == S_RESP) &  r_owner_cpu;
    assign vid_ack   = (r_state == S_RESP) & ~r_owner_cpu;
    assign cpu_rdata = w_cpu_rd_now ? mem_rdata : r_cpu_rdata;
    assign vid_rdata = w_vid_rd_now ? mem_rdata : r_vid_rdata;

    assign mem_en    = (r_state == S_ACCESS);
    assign mem_we    = (r_state == S_ACCESS) & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_arbiter
// Purpose  : Directed bench for vram_arbiter with a transaction-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_vram_arbiter;
    localparam int AW = 13;
    localparam int DW = 16;
    localparam int VB = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_ack;
    logic [DW-1:0] vid_rdata;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .VID_BURST(VB)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Synchronous single-port RAM behind the arbiter
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Transaction-level reference: idle -> one access cycle -> one response cycle
    int            m_phase = 0;
    int            m_burst = 0;
    bit            m_own_cpu, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_mem [0:(1<<AW)-1];
    bit            e_en, e_we, e_cack, e_vack, e_busy;
    logic [DW-1:0] e_rd;
    int            cyc = 0;
    int            cpu_acks = 0, vid_acks = 0, we_cycles = 0;
    bit            glog[$];

    always @(posedge clk) begin
        cyc++;
        e_en = 0; e_we = 0; e_cack = 0; e_vack = 0; e_busy = 0;
        if (reset) begin
            m_phase = 0;
            m_burst = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (cpu_req || vid_req) begin
                        m_own_cpu = cpu_req && !(vid_req && m_burst < VB);
                        m_addr    = m_own_cpu ? cpu_addr : vid_addr;
                        m_we      = m_own_cpu && cpu_we;
                        m_wdata   = cpu_wdata;
                        if (!cpu_req || m_own_cpu) m_burst = 0;
                        else if (m_burst < VB) m_burst++;
                        m_phase = 1;
                        e_en = 1; e_we = m_we; e_busy = 1;
                    end else begin
                        m_burst = 0;
                    end
                end
                1: begin
                    if (m_we) m_mem[m_addr] = m_wdata;
                    e_rd   = m_mem[m_addr];
                    e_cack = m_own_cpu;
                    e_vack = !m_own_cpu;
                    e_busy = 1;
                    m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
        #1;
        check("mem_en", mem_en, e_en);
        check("mem_we", mem_we, e_we);
        check("cpu_ack", cpu_ack, e_cack);
        check("vid_ack", vid_ack, e_vack);
        check("busy", busy, e_busy);
        if (e_en) check("mem_addr", mem_addr, m_addr);
        if (e_we) check("mem_wdata", mem_wdata, m_wdata);
        if (e_cack && !m_we) check("cpu_rdata", cpu_rdata, e_rd);
        if (e_vack) check("vid_rdata", vid_rdata, e_rd);
        if (cpu_ack) begin glog.push_back(1'b1); cpu_acks++; end
        if (vid_ack) begin glog.push_back(1'b0); vid_acks++; end
        if (mem_we) we_cycles++;
    end

    task automatic cpu_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output logic [DW-1:0] rd, output int lat);
        bit got;
        got = 0;
        rd  = 'x;
        lat = 0;
        @(negedge clk);
        cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #2;
            lat++;
            if (cpu_ack) begin rd = cpu_rdata; got = 1; end
        end
        if (!got) check("cpu_ack_timeout", 32'(got), 32'd1);
        @(negedge clk);
        cpu_req = 0;
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic [9:0]    order;
        int            lat, w0, start, first_c, a0, tk[8];
        bit            got;

        for (int i = 0; i < (1 << AW); i++) begin
            ram[i] = '0;
            m_mem[i] = '0;
        end
        repeat (2) @(negedge clk);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_vid_ack", vid_ack, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_busy", busy, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        reset = 0;
        repeat (2) @(negedge clk);

        // CPU write then read
        w0 = we_cycles;
        cpu_op(1, 13'h0010, 16'hBEEF, rd, lat);
        check("wr_we_cycles", we_cycles - w0, 1);
        cpu_op(0, 13'h0010, 16'h0000, rd, lat);
        check("rd_beef", rd, 16'hBEEF);
        check("rd_latency", lat, 2);

        // Boundary addresses
        cpu_op(1, 13'h0000, 16'h1234, rd, lat);
        cpu_op(1, 13'h1FFF, 16'hFFFF, rd, lat);
        cpu_op(0, 13'h0000, 16'h0000, rd, lat);
        check("rd_addr0", rd, 16'h1234);
        cpu_op(0, 13'h1FFF, 16'h0000, rd, lat);
        check("rd_addr1fff", rd, 16'hFFFF);

        // Simultaneous first request: video first, then CPU
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 13'h1FFF; vid_req = 1; vid_addr = 13'h0000;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #2;
            got = cpu_ack | vid_ack;
        end
        check("simul_vid_first", vid_ack, 1);
        check("simul_vid_data", vid_rdata, 16'h1234);
        @(negedge clk);
        vid_req = 0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #2;
            if (cpu_ack) begin got = 1; rd = cpu_rdata; end
        end
        check("simul_cpu_next", 32'(got), 1);
        check("simul_cpu_data", rd, 16'hFFFF);
        @(negedge clk);
        cpu_req = 0;
        repeat (2) @(negedge clk);

        // Starvation guard
        glog.delete();
        start = cyc;
        first_c = -1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0000; vid_req = 1; vid_addr = 13'h0010;
        for (int i = 0; i < 60 && glog.size() < 10; i++) begin
            @(posedge clk); #2;
            if (cpu_ack && first_c < 0) first_c = cyc - start;
        end
        @(negedge clk);
        cpu_req = 0; vid_req = 0;
        order = '0;
        for (int k = 0; k < 10 && k < glog.size(); k++) order[k] = glog[k];
        check("grant_count", glog.size(), 10);
        check("grant_order", order, 10'b1000010000);
        check("cpu_wait_le15", 32'(first_c >= 0 && first_c <= 15), 1);
        repeat (2) @(negedge clk);

        // Video-only stream, addresses 0..7
        w0 = we_cycles;
        a0 = vid_acks;
        vid_req = 1; vid_addr = 13'h0000;
        for (int k = 0; k < 8; k++) begin
            got = 0;
            for (int i = 0; i < 10 && !got; i++) begin
                @(posedge clk); #2;
                got = vid_ack;
            end
            tk[k] = cyc;
            if (k == 0) check("vid_stream_first", vid_rdata, 16'h1234);
            if (k > 0) check("vid_spacing", tk[k] - tk[k-1], 3);
            @(negedge clk);
            if (k == 7) vid_req = 0;
            else vid_addr = AW'(k + 1);
        end
        check("vid_stream_acks", vid_acks - a0, 8);
        check("vid_stream_no_we", we_cycles - w0, 0);
        repeat (2) @(negedge clk);

        // Reset in the middle of a CPU write access
        cpu_req = 1; cpu_we = 1; cpu_addr = 13'h0100; cpu_wdata = 16'hAAAA;
        @(posedge clk); #2;
        check("mid_rst_pre_en", mem_en, 1);
        check("mid_rst_pre_we", mem_we, 1);
        reset = 1;
        #1;
        check("mid_rst_en", mem_en, 0);
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_acks", 32'(cpu_ack | vid_ack), 0);
        a0 = cpu_acks + vid_acks;
        @(posedge clk);
        @(negedge clk);
        reset = 0; cpu_req = 0;
        repeat (6) @(posedge clk);
        #2;
        check("mid_rst_no_ack", cpu_acks + vid_acks - a0, 0);
        cpu_op(0, 13'h0010, 16'h0000, rd, lat);
        check("post_rst_rd", rd, 16'hBEEF);
        check("post_rst_lat", lat, 2);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
